// File: rtl/control_sequencer.sv
// Moore-FSM control unit driving the memory_system control word (fetch, decode, execute).
// Build option: define CU_ILLEGAL_TRAP_EN to halt on undefined opcodes instead of skipping them.
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] instruction,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       ir_sclr,
    output logic       mar_sclr,
    output logic       enaf,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       bank_wr_en,
    output logic [2:0] busB_addr,
    output logic [2:0] busC_addr,
    output logic       ir_en,
    output logic       mar_en,
    output logic       mdr_en,
    output logic       wr_rdn,
    output logic       mdr_alu_n,
    output logic [3:0] state,
    output logic       halted,
    output logic       illegal_op
);

    localparam logic [2:0] PC_ADDR     = 3'b000;
    localparam logic [2:0] DPTR_ADDR   = 3'b001;
    localparam logic [2:0] A_ADDR      = 3'b010;
    localparam logic [2:0] ACC_ADDR    = 3'b111;
    localparam logic [2:0] SELOP_PASSB = 3'b000;
    localparam logic [2:0] SELOP_ADD   = 3'b001;
    localparam logic [2:0] SELOP_INC   = 3'b110;

    localparam logic [4:0] OP_NOP    = 5'h00;
    localparam logic [4:0] OP_MOVK   = 5'h01;
    localparam logic [4:0] OP_MOVA   = 5'h02;
    localparam logic [4:0] OP_MOVRA  = 5'h03;
    localparam logic [4:0] OP_ADD    = 5'h04;
    localparam logic [4:0] OP_LOAD   = 5'h05;
    localparam logic [4:0] OP_STORE  = 5'h06;
    localparam logic [4:0] OP_JZ     = 5'h07;
    localparam logic [4:0] OP_HALT   = 5'h1F;

    // M0/W0 and M2/K2 have identical outputs, so each pair shares one state and
    // branches on the still-stable opcode; this keeps the encoding within 4 bits.
    typedef enum logic [3:0] {
        S_RST  = 4'd0,  S_F0 = 4'd1,  S_F1 = 4'd2,  S_DEC = 4'd3,
        S_K0   = 4'd4,  S_K1 = 4'd5,  S_K2 = 4'd6,  S_J2  = 4'd7,
        S_RA   = 4'd8,  S_RB = 4'd9,  S_RC = 4'd10, S_M0  = 4'd11,
        S_M1   = 4'd12, S_W1 = 4'd13, S_W2 = 4'd14, S_HALT = 4'd15
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_illegal_next;
    logic   w_unused_flags;

    assign w_unused_flags = C ^ N ^ P;
    assign state          = r_state;
    assign shamt          = 2'b00;

`ifdef CU_ILLEGAL_TRAP_EN
    assign w_illegal_next = S_HALT;
`else
    assign w_illegal_next = S_F0;
`endif

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and Moore control-word decode.
    always_comb begin
        w_next     = r_state;
        ir_sclr    = 1'b0;
        mar_sclr   = 1'b0;
        enaf       = 1'b0;
        selop      = SELOP_PASSB;
        bank_wr_en = 1'b0;
        busB_addr  = PC_ADDR;
        busC_addr  = PC_ADDR;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        wr_rdn     = 1'b0;
        mdr_alu_n  = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_RST: begin
                ir_sclr  = 1'b1;
                mar_sclr = 1'b1;
                w_next   = S_F0;
            end
            S_F0, S_K0: begin
                busB_addr = PC_ADDR;
                mar_en    = 1'b1;
                w_next    = (r_state == S_F0) ? S_F1 : S_K1;
            end
            S_F1: begin
                busB_addr  = PC_ADDR;
                selop      = SELOP_INC;
                busC_addr  = PC_ADDR;
                bank_wr_en = 1'b1;
                ir_en      = 1'b1;
                w_next     = S_DEC;
            end
            S_DEC: begin
                case (instruction)
                    OP_NOP:   w_next = S_F0;
                    OP_MOVK:  w_next = S_K0;
                    OP_MOVA:  w_next = S_RA;
                    OP_MOVRA: w_next = S_RB;
                    OP_ADD:   w_next = S_RC;
                    OP_LOAD:  w_next = S_M0;
                    OP_STORE: w_next = S_M0;
                    OP_JZ:    w_next = S_K0;
                    OP_HALT:  w_next = S_HALT;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = w_illegal_next;
                    end
                endcase
            end
            S_K1: begin
                busB_addr  = PC_ADDR;
                selop      = SELOP_INC;
                busC_addr  = PC_ADDR;
                bank_wr_en = 1'b1;
                mdr_en     = 1'b1;
                if (instruction == OP_JZ) begin
                    w_next = S_J2;
                end else begin
                    w_next = S_K2;
                end
            end
            S_K2: begin
                mdr_alu_n  = 1'b1;
                busC_addr  = ACC_ADDR;
                bank_wr_en = 1'b1;
                w_next     = S_F0;
            end
            S_J2: begin
                if (Z) begin
                    mdr_alu_n  = 1'b1;
                    busC_addr  = PC_ADDR;
                    bank_wr_en = 1'b1;
                end else begin
                    bank_wr_en = 1'b0;
                end
                w_next = S_F0;
            end
            S_RA: begin
                busB_addr  = A_ADDR;
                busC_addr  = ACC_ADDR;
                bank_wr_en = 1'b1;
                w_next     = S_F0;
            end
            S_RB: begin
                busB_addr  = ACC_ADDR;
                busC_addr  = A_ADDR;
                bank_wr_en = 1'b1;
                w_next     = S_F0;
            end
            S_RC: begin
                busB_addr  = A_ADDR;
                selop      = SELOP_ADD;
                enaf       = 1'b1;
                busC_addr  = ACC_ADDR;
                bank_wr_en = 1'b1;
                w_next     = S_F0;
            end
            S_M0: begin
                busB_addr = DPTR_ADDR;
                mar_en    = 1'b1;
                if (instruction == OP_STORE) begin
                    w_next = S_W1;
                end else begin
                    w_next = S_M1;
                end
            end
            S_M1: begin
                mdr_en = 1'b1;
                w_next = S_K2;
            end
            S_W1: begin
                busB_addr = ACC_ADDR;
                mdr_en    = 1'b1;
                w_next    = S_W2;
            end
            S_W2: begin
                wr_rdn = 1'b1;
                w_next = S_F0;
            end
            S_HALT: begin
                halted = 1'b1;
                w_next = S_HALT;
            end
            default: begin
                w_next = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a behavioural memory_system around the DUT, a directed
// vector table, hand-written sequences and random programs against an instruction-level model.
`timescale 1ns/1ps
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] instruction;
    logic       C = 1'b0, N = 1'b0, P = 1'b0, Z = 1'b0;
    logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en;
    logic       wr_rdn, mdr_alu_n, halted, illegal_op;
    logic [2:0] selop, busB_addr, busC_addr;
    logic [1:0] shamt;
    logic [3:0] unused_state;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .C(C), .N(N), .P(P), .Z(Z),
        .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop),
        .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
        .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n), .state(unused_state),
        .halted(halted), .illegal_op(illegal_op)
    );

    // Datapath stand-in. MDR takes the ALU result when ACC drives busB, otherwise memory.
    logic [7:0] bank[8], init_bank[8];
    logic [7:0] mem[256], init_mem[256];
    logic [7:0] ir, mar, mdr, w_busB, w_alu, w_busC;

    assign instruction = ir[4:0];

    always_comb begin
        w_busB = bank[busB_addr];
        case (selop)
            3'b001:  w_alu = bank[7] + w_busB;
            3'b110:  w_alu = w_busB + 8'd1;
            default: w_alu = w_busB;
        endcase
        w_busC = mdr_alu_n ? mdr : w_alu;
    end

    always @(posedge clk) begin
        if (!rst) begin
            bank <= init_bank;
            mem  <= init_mem;
            ir   <= 8'h00;
            mar  <= 8'h00;
            mdr  <= 8'h00;
        end else begin
            if (bank_wr_en) bank[busC_addr] <= w_busC;
            if (mar_sclr) mar <= 8'h00;
            else if (mar_en) mar <= w_busB;
            if (ir_sclr) ir <= 8'h00;
            else if (ir_en) ir <= mem[mar];
            if (mdr_en) mdr <= (busB_addr == 3'b111) ? w_alu : mem[mar];
            if (wr_rdn) mem[mar] <= mdr;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] ctl();
        return {ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en, wr_rdn,
                mdr_alu_n, halted, illegal_op, selop, busB_addr, busC_addr, shamt};
    endfunction

    localparam logic [21:0] CTL_RST  = {11'b11000000000, 11'd0};
    localparam logic [21:0] CTL_F0   = {11'b00000100000, 11'd0};
    localparam logic [21:0] CTL_HALT = {11'b00000000010, 11'd0};

    // Instruction-level reference model.
    typedef struct {
        int         cyc;
        logic [7:0] acc, a, pc, m;
        int         bw, ef, wr, il;
        bit         halt;
    } exp_t;

`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [7:0] m_pc, m_acc, m_a, m_dptr;
    logic [7:0] m_mem[256];

    task automatic model_init();
        m_mem  = init_mem;
        m_pc   = init_bank[0];
        m_dptr = init_bank[1];
        m_a    = init_bank[2];
        m_acc  = init_bank[7];
    endtask

    task automatic model_step(input logic z, output exp_t e);
        logic [4:0] op;
        op = m_mem[m_pc][4:0];
        m_pc = m_pc + 8'd1;
        e.cyc = 3; e.bw = 1; e.ef = 0; e.wr = 0; e.il = 0; e.halt = 1'b0;
        case (op)
            5'h00: ;
            5'h01: begin m_acc = m_mem[m_pc]; m_pc = m_pc + 8'd1; e.cyc = 6; e.bw = 3; end
            5'h02: begin m_acc = m_a; e.cyc = 4; e.bw = 2; end
            5'h03: begin m_a = m_acc; e.cyc = 4; e.bw = 2; end
            5'h04: begin m_acc = m_acc + m_a; e.cyc = 4; e.bw = 2; e.ef = 1; end
            5'h05: begin m_acc = m_mem[m_dptr]; e.cyc = 6; e.bw = 2; end
            5'h06: begin m_mem[m_dptr] = m_acc; e.cyc = 6; e.wr = 1; end
            5'h07: begin
                e.cyc = 6;
                e.bw  = z ? 3 : 2;
                if (z) m_pc = m_mem[m_pc];
                else   m_pc = m_pc + 8'd1;
            end
            5'h1F: e.halt = 1'b1;
            default: begin e.il = 1; e.halt = TRAP; end
        endcase
        e.acc = m_acc; e.a = m_a; e.pc = m_pc; e.m = m_mem[m_dptr];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1 chk("reset_held_ctl", ctl(), CTL_RST);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_state_ctl", ctl(), CTL_RST);
        @(negedge clk);
        chk("f0_after_rst_ctl", ctl(), CTL_F0);
    endtask

    task automatic wait_f1();
        bit seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ir_en) begin
                seen = 1'b1;
                break;
            end
        end
        chk("fetch_seen", seen, 1'b1);
    endtask

    // Called at the F1 sample of an instruction; runs it to the next F1 and checks results.
    task automatic exec(input string tag, input exp_t e, input logic zin);
        int cyc = 0, bw = 0, ef = 0, wr = 0, il = 0, bad = 0;
        bit seen = 1'b0;
        Z = zin;
        if (e.halt) begin
            @(negedge clk);
            chk({tag, " dec_illegal"}, illegal_op, e.il);
            @(negedge clk);
            chk({tag, " halted"}, halted, 1'b1);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0 && ir_en) begin
                seen = 1'b1;
                break;
            end
            cyc++;
            bw += int'(bank_wr_en);
            ef += int'(enaf);
            wr += int'(wr_rdn);
            il += int'(illegal_op);
            if ((wr_rdn && bank_wr_en) || (mar_en && mdr_en)) bad++;
            @(negedge clk);
        end
        chk({tag, " next_fetch"}, seen, 1'b1);
        chk({tag, " cycles"}, cyc, e.cyc);
        chk({tag, " acc"}, bank[7], e.acc);
        chk({tag, " a"}, bank[2], e.a);
        chk({tag, " pc"}, bank[0], e.pc);
        chk({tag, " mem_dptr"}, mem[bank[1]], e.m);
        chk({tag, " bank_writes"}, bw, e.bw);
        chk({tag, " enaf_cycles"}, ef, e.ef);
        chk({tag, " wr_cycles"}, wr, e.wr);
        chk({tag, " illegal_pulses"}, il, e.il);
        chk({tag, " exclusive_strobes"}, bad, 0);
    endtask

    task automatic run_model(input string tag, input int n, input int zmode, output bit stopped);
        exp_t e;
        logic z;
        stopped = 1'b0;
        model_init();
        do_reset();
        wait_f1();
        for (int i = 0; i < n; i++) begin
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            {C, N, P} = 3'($urandom);
            model_step(z, e);
            exec(tag, e, z);
            if (e.halt) begin
                stopped = 1'b1;
                break;
            end
        end
    endtask

    task automatic std_regs();
        for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) init_bank[i] = 8'h00;
        init_bank[1] = 8'h80;
        init_bank[2] = 8'h10;
        init_bank[7] = 8'h11;
        init_mem[8'h80] = 8'h77;
    endtask

    typedef struct {
        logic [7:0] op, opnd;
        logic       z;
        int         cyc;
        logic [7:0] acc, a, pc, m;
        int         bw, ef, wr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        exp_t e;
        bit   stopped;

        // A=10, ACC=11, DPTR=80, mem[80]=77 before every vector.
        vecs[0] = '{8'h00, 8'h00, 1'b0, 3, 8'h11, 8'h10, 8'h01, 8'h77, 1, 0, 0};
        vecs[1] = '{8'h01, 8'h5A, 1'b0, 6, 8'h5A, 8'h10, 8'h02, 8'h77, 3, 0, 0};
        vecs[2] = '{8'h02, 8'h00, 1'b0, 4, 8'h10, 8'h10, 8'h01, 8'h77, 2, 0, 0};
        vecs[3] = '{8'h03, 8'h00, 1'b0, 4, 8'h11, 8'h11, 8'h01, 8'h77, 2, 0, 0};
        vecs[4] = '{8'h04, 8'h00, 1'b0, 4, 8'h21, 8'h10, 8'h01, 8'h77, 2, 1, 0};
        vecs[5] = '{8'h05, 8'h00, 1'b0, 6, 8'h77, 8'h10, 8'h01, 8'h77, 2, 0, 0};
        vecs[6] = '{8'h06, 8'h00, 1'b0, 6, 8'h11, 8'h10, 8'h01, 8'h11, 1, 0, 1};
        vecs[7] = '{8'h07, 8'h40, 1'b1, 6, 8'h11, 8'h10, 8'h40, 8'h77, 3, 0, 0};
        vecs[8] = '{8'h07, 8'h40, 1'b0, 6, 8'h11, 8'h10, 8'h02, 8'h77, 2, 0, 0};
        vecs[9] = '{8'hE2, 8'h00, 1'b0, 4, 8'h10, 8'h10, 8'h01, 8'h77, 2, 0, 0};

        for (int v = 0; v < 10; v++) begin
            std_regs();
            init_mem[0] = vecs[v].op;
            init_mem[1] = vecs[v].opnd;
            do_reset();
            wait_f1();
            e.cyc = vecs[v].cyc; e.acc = vecs[v].acc; e.a = vecs[v].a; e.pc = vecs[v].pc;
            e.m = vecs[v].m; e.bw = vecs[v].bw; e.ef = vecs[v].ef; e.wr = vecs[v].wr;
            e.il = 0; e.halt = 1'b0;
            exec($sformatf("vec%0d", v), e, vecs[v].z);
        end

        // MOV ACC,#3 ; MOV ACC,A ; ADD ACC,A with A=10.
        std_regs();
        init_mem[0] = 8'h01; init_mem[1] = 8'h03; init_mem[2] = 8'h02; init_mem[3] = 8'h04;
        run_model("alu_seq", 3, 0, stopped);
        chk("alu_seq acc_final", bank[7], 8'h20);

        // Store ACC=33 to [80], clobber ACC, load it back.
        std_regs();
        init_bank[7] = 8'h33;
        init_mem[0] = 8'h06; init_mem[1] = 8'h01; init_mem[2] = 8'h00; init_mem[3] = 8'h05;
        run_model("store_load", 3, 0, stopped);
        chk("store_load acc_final", bank[7], 8'h33);

        // Undefined opcode, then MOV ACC,#5A (skipped or trapped depending on build).
        std_regs();
        init_mem[0] = 8'h15; init_mem[1] = 8'h01; init_mem[2] = 8'h5A;
        run_model("illegal", 2, 0, stopped);
        chk("illegal stopped", stopped, TRAP);

        // HALT holds with every control low.
        std_regs();
        init_mem[0] = 8'h1F;
        run_model("halt", 1, 0, stopped);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("halt_hold_ctl", ctl(), CTL_HALT);
        end

        // Reset in the middle of MOV ACC,#k restarts cleanly.
        std_regs();
        init_mem[0] = 8'h01; init_mem[1] = 8'h5A;
        do_reset();
        wait_f1();
        repeat (3) @(negedge clk);
        run_model("mid_reset", 1, 0, stopped);
        chk("mid_reset acc", bank[7], 8'h5A);

        // Random programs against the reference model.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) init_mem[i] = {3'($urandom), 5'($urandom_range(0, 7))};
            for (int i = 0; i < 8; i++) init_bank[i] = 8'($urandom);
            init_bank[0] = 8'h00;
            init_bank[1] = {1'b1, 7'($urandom)};
            run_model($sformatf("rand%0d", p), 40, 2, stopped);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit that drives the memory_system control word (register-bank, MAR/MDR/IR, ALU select, memory write strobe) from the decoded instruction and flags.
- Replaces the hand-driven control vectors with a Moore FSM covering fetch, decode and execute for a fixed opcode subset.
- Sits beside memory_system: consumes instruction and C/N/P/Z, produces every memory_system control input.

Parameters:
- PC_ADDR, 3'b000, register-bank address of PC
- DPTR_ADDR, 3'b001, address of DPTR
- A_ADDR, 3'b010, address of A
- ACC_ADDR, 3'b111, address of ACC
- SELOP_PASSB, 3'b000, ALU op: output = busB
- SELOP_ADD, 3'b001, ALU op: ACC + busB
- SELOP_INC, 3'b110, ALU op: busB + 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instruction  in  5  opcode from IR
- C, N, P, Z  in  1 each  ALU flags; only Z is used
- ir_sclr, mar_sclr  out  1  synchronous clears of IR/MAR
- enaf  out  1  flag-register update enable
- selop  out  3  ALU operation select
- shamt  out  2  shift amount; constant 0
- bank_wr_en  out  1  register-bank write enable
- busB_addr, busC_addr  out  3  bank read/write addresses
- ir_en, mar_en, mdr_en  out  1  IR/MAR/MDR load enables
- wr_rdn  out  1  1 = write MDR to mem[MAR]
- mdr_alu_n  out  1  busC source: 1 = MDR, 0 = ALU
- state  out  4  current FSM state, for debug
- halted  out  1  high while in HALT
- illegal_op  out  1  one-cycle pulse in DEC on an undefined opcode

Behaviour:
- Moore outputs decoded from state.
  - Every control output not listed for a state is 0.
  - selop defaults to SELOP_PASSB; addresses default to 0.
- Reset (rst=0, async): state <= RST. RST drives ir_sclr=1, mar_sclr=1, all else 0. rst release mid-instruction always restarts from RST.
- RST -> F0.
- Fetch and decode:
  - F0: busB=PC, mar_en=1 (MAR<-PC).
  - F1: busB=PC, selop=INC, busC=PC, bank_wr_en=1, ir_en=1 (PC++, IR<-mem[MAR]).
  - DEC: no controls; instruction is stable. Branches on opcode.
- Opcode decode:
  - 5'h00 NOP -> F0.
  - 5'h01 MOV ACC,#k -> K0.
  - 5'h02 MOV ACC,A -> RA.
  - 5'h03 MOV A,ACC -> RB.
  - 5'h04 ADD ACC,A -> RC.
  - 5'h05 MOV ACC,[DPTR] -> M0.
  - 5'h06 MOV [DPTR],ACC -> W0.
  - 5'h07 JZ #k -> K0.
  - 5'h1F HALT -> HALT.
  - Any other opcode: illegal_op=1 in DEC, then F0 (treated as NOP).
- Immediate-operand states:
  - K0: busB=PC, mar_en=1.
  - K1: busB=PC, selop=INC, busC=PC, bank_wr_en=1, mdr_en=1 (PC++, MDR<-mem).
  - K1 -> K2 for opcode 01, -> J2 for opcode 07.
  - K2: mdr_alu_n=1, busC=ACC, bank_wr_en=1 -> F0.
  - J2: if Z=1 (sampled in J2), mdr_alu_n=1, busC=PC, bank_wr_en=1; else no write. -> F0.
- Register / ALU states:
  - RA: busB=A, selop=PASSB, busC=ACC, bank_wr_en=1 -> F0.
  - RB: busB=ACC, selop=PASSB, busC=A, bank_wr_en=1 -> F0.
  - RC: busB=A, selop=ADD, enaf=1, busC=ACC, bank_wr_en=1 -> F0.
- Memory states:
  - M0: busB=DPTR, mar_en=1.
  - M1: mdr_en=1.
  - M2: same outputs as K2 -> F0.
  - W0: busB=DPTR, mar_en=1.
  - W1: busB=ACC, selop=PASSB, mdr_en=1, mdr_alu_n=0 (MDR<-ALU).
  - W2: wr_rdn=1 -> F0.
- HALT: halted=1, all controls 0. Stays in HALT until reset.
- Cycle counts, including F0/F1/DEC:
  - NOP 3
  - MOV ACC,#k 6
  - JZ 6
  - register and ALU ops 4
  - MOV ACC,[DPTR] 6
  - MOV [DPTR],ACC 6
- wr_rdn and bank_wr_en are never both 1 in the same state. mar_en and mdr_en are never both 1 in the same state.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode pulses illegal_op in DEC, then enters HALT (halted=1) until reset.
- Undefined: illegal_op pulses, then F0 (NOP).

Test Plan:
- Reset: rst=0 for 20 ns, then released -> one cycle of RST with ir_sclr=mar_sclr=1, then F0 with mar_en=1, busB_addr=000.
- Program 01,5A at address 0 -> after 6 cycles ACC_m=8'h5A, PC_m=8'h02, state=F0. In K2, bank_wr_en=1, busC_addr=111, mdr_alu_n=1.
- Program 01,03 / 02 / 04, with A preloaded 8'h10 -> ACC=8'h10 after MOV ACC,A; ACC=8'h20 after ADD. enaf=1 only in RC.
- JZ: program 07,40 run once with Z=1 and once with Z=0 -> Z=1 gives PC_m=8'h40; Z=0 gives PC_m=8'h02. No bank write in J2 when Z=0.
- Program 06 with DPTR=8'h80, ACC=8'h33 -> in W2 wr_rdn=1 for exactly 1 cycle; mem[8'h80]=8'h33. Then program 05 reads back ACC=8'h33.
- Opcode 5'h15 -> illegal_op pulses once, then F0. With CU_ILLEGAL_TRAP_EN: halted=1 and held. Opcode 1F -> halted=1 and all controls 0 for 20 cycles.
